// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: none (declarations only).
// Backpressure: not applicable.
package div_pkg;

    // Default operand width and the matching iteration-counter width.
    localparam int N_DEFAULT = 8;
    localparam int CNT_W     = $clog2(N_DEFAULT + 1);

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width needed to hold an iteration count of 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/add_sub_unit.sv
// W-bit ripple-carry adder/subtractor: i_m=0 gives a+b, i_m=1 gives a-b (two's complement).
// Latency: combinational.
// Backpressure: none; o_cout=1 in subtract mode means no borrow (a >= b).
module add_sub_unit #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_m,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0]   w_c;
    logic [W-1:0] w_bx;

    // Subtract mode inverts b and injects the +1 through the carry-in.
    assign w_c[0] = i_m;

    for (genvar g = 0; g < W; g++) begin : g_bit
        assign w_bx[g]    = i_b[g] ^ i_m;
        assign o_sum[g]   = i_a[g] ^ w_bx[g] ^ w_c[g];
        assign w_c[g + 1] = (i_a[g] & w_bx[g]) | (w_c[g] & (i_a[g] ^ w_bx[g]));
    end

    assign o_cout = w_c[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned N-bit restoring divider, one quotient bit per clock.
// Latency: start accepted at edge k -> done pulse after edge k+N+1 (k+1 for divide by zero).
// Backpressure: start is ignored while busy; a start during DONE is accepted back-to-back.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero
);

    localparam int CW = cnt_w(N);

    state_t          r_state;
    logic [N:0]      r_r;       // partial remainder, one guard bit wide
    logic [N-1:0]    r_q;       // dividend shifting out / quotient shifting in
    logic [N-1:0]    r_d;       // captured divisor
    logic [CW-1:0]   r_cnt;
    logic            r_dbz;

    logic [N:0]      w_r_sh;
    logic [N:0]      w_trial;
    logic            w_cout;
    logic            w_unused_msb;

    // R never reaches 2^N before the shift (R < D), so its guard bit is always
    // zero on entry to an iteration and is dropped by the shift.
    assign w_r_sh       = {r_r[N-1:0], r_q[N-1]};
    assign w_unused_msb = r_r[N];

    add_sub_unit #(
        .W (N + 1)
    ) u_add_sub (
        .i_a    (w_r_sh),
        .i_b    ({1'b0, r_d}),
        .i_m    (1'b1),
        .o_sum  (w_trial),
        .o_cout (w_cout)
    );

    // Control FSM, shift/iteration datapath and registered result outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= IDLE;
            r_r           <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_cnt         <= '0;
            r_dbz         <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (r_state == DONE) begin
                        o_done        <= 1'b1;
                        o_quotient    <= r_q;
                        o_remainder   <= r_r[N-1:0];
                        o_div_by_zero <= r_dbz;
                    end
                    if (i_start) begin
                        r_d   <= i_divisor;
                        r_cnt <= '0;
                        if (i_divisor == '0) begin
                            // Zero divisor skips RUN; DONE reports all-ones / dividend.
                            r_dbz   <= 1'b1;
                            r_q     <= '1;
                            r_r     <= {1'b0, i_dividend};
                            r_state <= DONE;
                            o_busy  <= 1'b0;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_q     <= i_dividend;
                            r_r     <= '0;
                            r_state <= RUN;
                            o_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Keep the trial difference only when it did not borrow.
                    r_r   <= w_cout ? w_trial : w_r_sh;
                    r_q   <= {r_q[N-2:0], w_cout};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= DONE;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised checks of the sequential restoring divider (N=8).
// Latency: expects done N+1 cycles after start (1 cycle for divide by zero).
// Backpressure: exercises start-while-busy and start-in-DONE handshakes.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int total = 0;
    int bad   = 0;

    seq_restoring_divider #(.N(8)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start sampled at the posedge between the two negedges; operands are scrambled afterwards.
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
    endtask

    // Counts cycles (and busy cycles) until done, bounded.
    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bn++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_op(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er,
                            input logic edbz, input string tag);
        int n;
        int bn;
        launch(a, b);
        wait_done(n, bn);
        chk({tag, "_lat"},  n,  (b == 0) ? 1 : 9);
        chk({tag, "_busy"}, bn, (b == 0) ? 0 : 8);
        chk({tag, "_q"},    quotient,    eq);
        chk({tag, "_r"},    remainder,   er);
        chk({tag, "_dbz"},  div_by_zero, edbz);
        @(negedge clk);
        chk({tag, "_done1"}, done, 1'b0);
    endtask

    initial begin
        int n;
        int bn;
        int pulses;
        logic [7:0] a;
        logic [7:0] b;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q",    quotient, 8'd0);
        chk("rst_r",    remainder, 8'd0);
        chk("rst_dbz",  div_by_zero, 1'b0);
        rst_n = 1'b1;

        // Basic and edge values.
        check_op(8'd100, 8'd7,   8'd14,  8'd2,   1'b0, "d100_7");
        check_op(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, "d255_1");
        check_op(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, "d5_9");
        check_op(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, "d255_255");
        check_op(8'd0,   8'd3,   8'd0,   8'd0,   1'b0, "d0_3");

        // Divide by zero, then a normal op clears the flag.
        check_op(8'd200, 8'd0,   8'd255, 8'd200, 1'b1, "dz200");
        check_op(8'd9,   8'd3,   8'd3,   8'd0,   1'b0, "d9_3");

        // Start pulsed while busy is ignored.
        launch(8'd100, 8'd7);
        repeat (2) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, bn);
        chk("ign_lat", n + 3, 9);
        chk("ign_q",   quotient, 8'd14);
        chk("ign_r",   remainder, 8'd2);
        @(negedge clk);

        // Start in the DONE-state cycle gives back-to-back operation.
        launch(8'd20, 8'd4);
        repeat (8) @(negedge clk);
        chk("b2b_busy_low", busy, 1'b0);
        start    = 1'b1;
        dividend = 8'd81;
        divisor  = 8'd9;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_first_done", done, 1'b1);
        chk("b2b_first_q",    quotient, 8'd5);
        chk("b2b_first_r",    remainder, 8'd0);
        @(negedge clk);
        wait_done(n, bn);
        chk("b2b_lat", n + 1, 9);
        chk("b2b_q",   quotient, 8'd9);
        chk("b2b_r",   remainder, 8'd0);
        @(negedge clk);

        // Reset in the middle of RUN discards the operation.
        launch(8'd200, 8'd3);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", busy, 1'b0);
        chk("mid_done", done, 1'b0);
        chk("mid_q",    quotient, 8'd0);
        chk("mid_r",    remainder, 8'd0);
        chk("mid_dbz",  div_by_zero, 1'b0);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        chk("mid_nodone", pulses, 0);
        check_op(8'd200, 8'd3, 8'd66, 8'd2, 1'b0, "d200_3");

        // Random operand pairs, roughly one in eight with a zero divisor.
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (b == 8'd0)
                check_op(a, b, 8'd255, a, 1'b1, "rnd");
            else
                check_op(a, b, a / b, a % b, 1'b0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
Iterative unsigned N-bit restoring divider producing one quotient bit per clock. It is built on an add/sub datapath operating in subtract mode (m=1). The divider performs the inverse operation to the team's combinational add/sub and multiply units and sits beside them in the arithmetic block. A start/busy/done handshake connects it to the controlling FSM or testbench.

Parameters:
N, 8, operand/quotient/remainder width in bits (N >= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous, active-low reset
start  input  1  request new division; sampled only when busy=0
dividend  input  N  unsigned dividend, captured on accepted start
divisor  input  N  unsigned divisor, captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when results become valid
quotient  output  N  unsigned quotient, held until next accepted start
remainder  output  N  unsigned remainder, held until next accepted start
div_by_zero  output  1  set with done when captured divisor==0; held with results

Behaviour:
- Reset (rst_n=0 at rising edge): state=IDLE; busy, done, div_by_zero, quotient, remainder all 0; iteration counter 0. Reset overrides everything, including mid-RUN; the partial result is discarded.
- States:
  - IDLE: busy=0. If start=1, capture operands and clear div_by_zero. If divisor==0, go to DONE. Otherwise go to RUN with R=0 (N+1 bits), Q=dividend, count=0.
  - RUN: busy=1. Each cycle:
    - {R,Q} <<= 1.
    - Compute trial = R_shifted - {0,D} on the (N+1)-bit add/sub in subtract mode.
    - If carry-out=1 (no borrow): R=trial, Q[0]=1. Otherwise R unchanged (restore), Q[0]=0.
    - count++. After the N-th iteration, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle. Latch quotient=Q and remainder=R[N-1:0]. Next state is IDLE.
  - A start asserted during DONE is accepted exactly as in IDLE, giving back-to-back operation.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+N+1. Divide-by-zero gives done in the cycle after edge k+1.
- Divide by zero: quotient = all ones, remainder = dividend, div_by_zero=1.
- start while busy=1 is ignored; operands are not re-captured.
- Operand inputs may change freely after capture without affecting the result.
- Invariant on done (divisor != 0): dividend == quotient*divisor + remainder and remainder < divisor.
- Outputs hold their values between done and the next accepted start. They update only at DONE.

Decomposition:
- Package div_pkg holds:
  - state typedef {IDLE, RUN, DONE}, 2-bit encoding
  - counter width constant CNT_W = $clog2(N+1)
- Natural sub-module: add_sub_unit, a parameterised W-bit ripple add/sub with inputs a, b, m and outputs sum, cout. It is instantiated with W=N+1, m tied to 1.
- The FSM, shift registers and counter stay in the top-level module.

Test Plan:
- Basic division: N=8, 100/7 -> after 9 cycles done pulse, quotient=14, remainder=2, div_by_zero=0; busy high for exactly 8 cycles.
- Edge values: 255/1 -> q=255, r=0. 5/9 -> q=0, r=5. 255/255 -> q=1, r=0. 0/3 -> q=0, r=0.
- Divide by zero: 200/0 -> done on the 2nd cycle, q=255, r=200, div_by_zero=1. A following 9/3 clears the flag and gives q=3, r=0.
- Handshake rules:
  - Start 100/7, then pulse start with 50/5 at RUN cycle 3 -> ignored, result 14 r 2.
  - Assert start in the DONE cycle with 81/9 -> q=9, r=0 with no idle gap.
- Reset mid-op: start 200/3, drop rst_n at RUN cycle 4 -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent 200/3 gives q=66, r=2.
- Random self-check: 1000 random operand pairs including zero divisors; check the invariant, latency N+1 and the single-cycle done.
